// File: rtl/mcpu_seq.sv
// Multi-cycle fetch/operand/execute sequencer for the mcpu core.
// RAM access uses a req/ack handshake and is guarded by a watchdog that traps into FAULT.
module mcpu_seq #(
   parameter int SKIP_OPL = 1,
   parameter int TIMEOUT  = 16,
   parameter int TO_W     = 5,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [7:0]       opc,
   input  logic             exe_mem,
   input  logic             exe_wr,
   input  logic             exe_hlt,
   input  logic [1:0]       exe_pcinc,
   input  logic             mem_ack,
   output logic [2:0]       st,
   output logic             mem_req,
   output logic             mem_we,
   output logic             opc_ld,
   output logic             opl_ld,
   output logic             exe_commit,
   output logic [1:0]       pcinc,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      OPCFT = 3'd1,
      OPLFT = 3'd2,
      EXE   = 3'd3,
      HALT  = 3'd4,
      FAULT = 3'd5
   } state_t;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);
   localparam bit              WD_EN  = (TIMEOUT != 0);

   state_t          state, state_nxt;
   logic            run_q, start, skip, timeout;
   logic [TO_W-1:0] wd;
   logic            unused_opc;

   assign start      = run & ~run_q;
   assign skip       = (SKIP_OPL != 0) && (opc[1:0] == 2'b00);
   assign st         = state;
   assign unused_opc = ^opc[7:2];

   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      opc_ld     = 1'b0;
      opl_ld     = 1'b0;
      exe_commit = 1'b0;
      pcinc      = 2'b00;
      timeout    = 1'b0;
      case (state)
         IDLE, HALT: if (start) state_nxt = OPCFT;
         OPCFT: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               opc_ld    = 1'b1;
               pcinc     = 2'b01;
               state_nxt = OPLFT;
            end
         end
         OPLFT: begin
            if (skip) state_nxt = EXE;
            else begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  opl_ld    = 1'b1;
                  pcinc     = opc[0] ? 2'b10 : (opc[1] ? 2'b11 : 2'b01);
                  state_nxt = EXE;
               end
            end
         end
         EXE: begin
            if (exe_hlt) begin
               exe_commit = 1'b1;
               state_nxt  = HALT;
            end else if (!exe_mem) begin
               exe_commit = 1'b1;
               pcinc      = exe_pcinc;
               state_nxt  = OPCFT;
            end else begin
               mem_req = 1'b1;
               mem_we  = exe_wr;
               if (mem_ack) begin
                  exe_commit = 1'b1;
                  pcinc      = exe_pcinc;
                  state_nxt  = OPCFT;
               end
            end
         end
         FAULT: ;
         default: state_nxt = IDLE;
      endcase
      // A pending request that has waited TIMEOUT cycles traps; strobes are already 0 without ack.
      timeout = WD_EN && mem_req && !mem_ack && (wd == TO_LIM);
      if (timeout) state_nxt = FAULT;
      halted = (state == HALT);
      fault  = (state == FAULT);
      // Reset dominates: nothing may commit or request in a reset cycle.
      if (rst) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         opc_ld     = 1'b0;
         opl_ld     = 1'b0;
         exe_commit = 1'b0;
         pcinc      = 2'b00;
         halted     = 1'b0;
         fault      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         run_q     <= 1'b0;
         wd        <= '0;
         instr_cnt <= '0;
      end else begin
         state <= state_nxt;
         run_q <= run;
         if (!WD_EN || (state_nxt != state) || !mem_req || mem_ack) wd <= '0;
         else                                                       wd <= wd + TO_W'(1);
         if (exe_commit && (instr_cnt != '1)) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mcpu_seq.sv
// Directed, table-driven bench for mcpu_seq: one vector per clock cycle,
// plus a hand-written run that drives the retired counter into saturation.
module tb_mcpu_seq;

   logic       clk = 1'b0;
   logic       rst, run, exe_mem, exe_wr, exe_hlt, mem_ack;
   logic [7:0] opc;
   logic [1:0] exe_pcinc;
   logic [2:0] st;
   logic       mem_req, mem_we, opc_ld, opl_ld, exe_commit, halted, fault;
   logic [1:0] pcinc;
   logic [2:0] instr_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mcpu_seq #(.SKIP_OPL(1), .TIMEOUT(4), .TO_W(3), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .run(run), .opc(opc), .exe_mem(exe_mem), .exe_wr(exe_wr),
      .exe_hlt(exe_hlt), .exe_pcinc(exe_pcinc), .mem_ack(mem_ack), .st(st),
      .mem_req(mem_req), .mem_we(mem_we), .opc_ld(opc_ld), .opl_ld(opl_ld),
      .exe_commit(exe_commit), .pcinc(pcinc), .halted(halted), .fault(fault),
      .instr_cnt(instr_cnt)
   );

   typedef struct packed {
      logic       rst, run;
      logic [7:0] opc;
      logic       mem, wr, hlt;
      logic [1:0] epc;
      logic       ack;
      logic [14:0] exp;
   } vec_t;

   function automatic vec_t v(input logic r, input logic rn, input logic [7:0] o,
                              input logic m, input logic w, input logic h,
                              input logic [1:0] ep, input logic a,
                              input logic [2:0] s, input logic rq, input logic we,
                              input logic ol, input logic ll, input logic cm,
                              input logic [1:0] pc, input logic hl, input logic ft,
                              input logic [2:0] cnt);
      vec_t t;
      t.rst = r; t.run = rn; t.opc = o; t.mem = m; t.wr = w; t.hlt = h;
      t.epc = ep; t.ack = a;
      t.exp = {s, rq, we, ol, ll, cm, pc, hl, ft, cnt};
      return t;
   endfunction

   function automatic logic [14:0] got();
      return {st, mem_req, mem_we, opc_ld, opl_ld, exe_commit, pcinc, halted, fault, instr_cnt};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[38];

   initial begin
      // reset, then run held high across a full 2-byte op, a skip op and a waited store
      vecs[0]  = v(1,0,8'h00,0,0,0,2'b00,0, 3'd0,0,0,0,0,0,2'b00,0,0,3'd0);
      vecs[1]  = v(1,0,8'h00,0,0,0,2'b00,0, 3'd0,0,0,0,0,0,2'b00,0,0,3'd0);
      vecs[2]  = v(0,1,8'h81,0,0,0,2'b01,1, 3'd0,0,0,0,0,0,2'b00,0,0,3'd0);
      vecs[3]  = v(0,1,8'h81,0,0,0,2'b01,1, 3'd1,1,0,1,0,0,2'b01,0,0,3'd0);
      vecs[4]  = v(0,1,8'h81,0,0,0,2'b01,1, 3'd2,1,0,0,1,0,2'b10,0,0,3'd0);
      vecs[5]  = v(0,1,8'h81,0,0,0,2'b01,1, 3'd3,0,0,0,0,1,2'b01,0,0,3'd0);
      vecs[6]  = v(0,1,8'h00,0,0,0,2'b01,1, 3'd1,1,0,1,0,0,2'b01,0,0,3'd1);
      vecs[7]  = v(0,1,8'h00,1,1,0,2'b10,1, 3'd2,0,0,0,0,0,2'b00,0,0,3'd1);
      vecs[8]  = v(0,1,8'h00,1,1,0,2'b10,0, 3'd3,1,1,0,0,0,2'b00,0,0,3'd1);
      vecs[9]  = v(0,1,8'h00,1,1,0,2'b10,0, 3'd3,1,1,0,0,0,2'b00,0,0,3'd1);
      vecs[10] = v(0,1,8'h00,1,1,0,2'b10,0, 3'd3,1,1,0,0,0,2'b00,0,0,3'd1);
      vecs[11] = v(0,1,8'h00,1,1,0,2'b10,1, 3'd3,1,1,0,0,1,2'b10,0,0,3'd1);
      // opc[1:0]=10 operand fetch, then HLT and restart from HALT
      vecs[12] = v(0,0,8'h02,0,0,0,2'b00,1, 3'd1,1,0,1,0,0,2'b01,0,0,3'd2);
      vecs[13] = v(0,0,8'h02,0,0,0,2'b00,1, 3'd2,1,0,0,1,0,2'b11,0,0,3'd2);
      vecs[14] = v(0,0,8'h02,0,0,1,2'b11,0, 3'd3,0,0,0,0,1,2'b00,0,0,3'd2);
      vecs[15] = v(0,0,8'h02,0,0,0,2'b00,0, 3'd4,0,0,0,0,0,2'b00,1,0,3'd3);
      vecs[16] = v(0,0,8'h02,0,0,0,2'b00,0, 3'd4,0,0,0,0,0,2'b00,1,0,3'd3);
      vecs[17] = v(0,1,8'h81,0,0,0,2'b00,0, 3'd4,0,0,0,0,0,2'b00,1,0,3'd3);
      // no ack in OPCFT: five request cycles then FAULT; run pulses ignored
      vecs[18] = v(0,1,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd3);
      vecs[19] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd3);
      vecs[20] = v(0,1,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd3);
      vecs[21] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd3);
      vecs[22] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd3);
      vecs[23] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd5,0,0,0,0,0,2'b00,0,1,3'd3);
      vecs[24] = v(0,1,8'h81,0,0,0,2'b00,1, 3'd5,0,0,0,0,0,2'b00,0,1,3'd3);
      vecs[25] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd5,0,0,0,0,0,2'b00,0,1,3'd3);
      vecs[26] = v(1,0,8'h81,0,0,0,2'b00,0, 3'd5,0,0,0,0,0,2'b00,0,0,3'd3);
      vecs[27] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd0,0,0,0,0,0,2'b00,0,0,3'd0);
      // ack arriving on the timeout cycle wins; then reset mid-EXE with ack high
      vecs[28] = v(0,1,8'h81,0,0,0,2'b00,0, 3'd0,0,0,0,0,0,2'b00,0,0,3'd0);
      vecs[29] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd0);
      vecs[30] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd0);
      vecs[31] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd0);
      vecs[32] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd1,1,0,0,0,0,2'b00,0,0,3'd0);
      vecs[33] = v(0,0,8'h81,0,0,0,2'b00,1, 3'd1,1,0,1,0,0,2'b01,0,0,3'd0);
      vecs[34] = v(0,0,8'h81,0,0,0,2'b00,1, 3'd2,1,0,0,1,0,2'b10,0,0,3'd0);
      vecs[35] = v(0,0,8'h81,1,0,0,2'b01,0, 3'd3,1,0,0,0,0,2'b00,0,0,3'd0);
      vecs[36] = v(1,0,8'h81,1,0,0,2'b01,1, 3'd3,0,0,0,0,0,2'b00,0,0,3'd0);
      vecs[37] = v(0,0,8'h81,0,0,0,2'b00,0, 3'd0,0,0,0,0,0,2'b00,0,0,3'd0);

      rst = 1'b1; run = 1'b0; opc = 8'h00; exe_mem = 1'b0; exe_wr = 1'b0;
      exe_hlt = 1'b0; exe_pcinc = 2'b00; mem_ack = 1'b0;
      cyc();

      for (int i = 0; i < 38; i++) begin
         rst = vecs[i].rst; run = vecs[i].run; opc = vecs[i].opc;
         exe_mem = vecs[i].mem; exe_wr = vecs[i].wr; exe_hlt = vecs[i].hlt;
         exe_pcinc = vecs[i].epc; mem_ack = vecs[i].ack;
         @(negedge clk);
         n_cmp++;
         if (got() !== vecs[i].exp) begin
            n_err++;
            $display("FAIL vec%0d: got st/req/we/oll/lld/cm/pc/hl/ft/cnt=%b, expected %b",
                     i, got(), vecs[i].exp);
         end
         cyc();
      end

      // back-to-back skip ops with zero-wait RAM: one commit every 3 cycles, saturating at 7
      rst = 1'b0; run = 1'b1; opc = 8'h00; exe_mem = 1'b0; exe_wr = 1'b0;
      exe_hlt = 1'b0; exe_pcinc = 2'b01; mem_ack = 1'b1;
      cyc();
      run = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         repeat (3) cyc();
         @(negedge clk);
         n_cmp++;
         if (instr_cnt !== 3'((k > 7) ? 7 : k) || st !== 3'd1) begin
            n_err++;
            $display("FAIL sat_k%0d: got cnt=%0d st=%0d, expected cnt=%0d st=1",
                     k, instr_cnt, st, (k > 7) ? 7 : k);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
